// File: rtl/imem_pkg.sv
// Shared types and constants for the Y86-64 instruction memory loader.
package imem_pkg;
   typedef enum logic [1:0] {CLEAR, IDLE, LOAD, DRAIN} state_t;
   localparam int INSTR_BYTES = 10;
   localparam logic [7:0] HALT_BYTE = 8'h00;
endpackage

// File: rtl/imem_window.sv
// Combinational fetch window: gathers INSTR_BYTES little-endian bytes at rd_pc.
module imem_window
   import imem_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 10
) (
   input  logic [63:0]                rd_pc,
   input  logic [MEM_BYTES-1:0][7:0]  mem,
   output logic [INSTR_BYTES*8-1:0]   rd_instr,
   output logic                       rd_err
);

   // 65-bit sums so a PC near 2^64 cannot wrap back into low memory.
   for (genvar i = 0; i < INSTR_BYTES; i++) begin : g_byte
      logic [64:0] addr;
      assign addr = {1'b0, rd_pc} + 65'(i);
      assign rd_instr[i*8 +: 8] = (addr < 65'(MEM_BYTES)) ? mem[addr[ADDR_W-1:0]] : 8'h00;
   end

   assign rd_err = rd_pc > 64'(MEM_BYTES - INSTR_BYTES);

endmodule

// File: rtl/imem_loader.sv
// Instruction memory owner: clears to halt after reset, loads a byte stream
// at a chosen base, and serves the fetch window.
module imem_loader
   import imem_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 10
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     load_start,
   input  logic [ADDR_W-1:0]        load_base,
   input  logic                     in_valid,
   input  logic [7:0]               in_data,
   input  logic                     in_last,
   output logic                     in_ready,
   output logic                     busy,
   output logic                     load_done,
   output logic                     load_err,
   output logic [ADDR_W:0]          load_count,
   input  logic [63:0]              rd_pc,
   output logic [INSTR_BYTES*8-1:0] rd_instr,
   output logic                     rd_err
);

   localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(MEM_BYTES - 1);

   state_t                    state, state_nx;
   logic [ADDR_W:0]           ptr, ptr_nx;
   logic [ADDR_W:0]           cnt_nx;
   logic                      err_nx, done_nx;
   logic                      we;
   logic [7:0]                wd;
   logic [MEM_BYTES-1:0][7:0] mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= CLEAR;
         ptr        <= '0;
         load_count <= '0;
         load_err   <= 1'b0;
         load_done  <= 1'b0;
      end else begin
         state      <= state_nx;
         ptr        <= ptr_nx;
         load_count <= cnt_nx;
         load_err   <= err_nx;
         load_done  <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      cnt_nx   = load_count;
      err_nx   = load_err;
      done_nx  = 1'b0;
      we       = 1'b0;
      wd       = in_data;
      in_ready = 1'b0;
      unique case (state)
         CLEAR: begin
            // ptr doubles as the clear address
            we     = 1'b1;
            wd     = HALT_BYTE;
            ptr_nx = ptr + ONE;
            if (ptr == LAST_ADDR) begin
               ptr_nx   = '0;
               state_nx = IDLE;
            end
         end
         IDLE: begin
            if (load_start) begin
               ptr_nx   = {1'b0, load_base};
               cnt_nx   = '0;
               err_nx   = 1'b0;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (ptr[ADDR_W]) begin
                  err_nx   = 1'b1;
                  state_nx = in_last ? IDLE : DRAIN;
               end else begin
                  we     = 1'b1;
                  ptr_nx = ptr + ONE;
                  cnt_nx = load_count + ONE;
                  if (in_last) begin
                     done_nx  = 1'b1;
                     state_nx = IDLE;
                  end
               end
            end
         end
         DRAIN: begin
            in_ready = 1'b1;
            if (in_valid && in_last) state_nx = IDLE;
         end
         default: state_nx = CLEAR;
      endcase
   end

   assign busy = (state != IDLE);

   // Array has no reset; CLEAR is what zeroes it.
   always_ff @(posedge clk) begin
      if (we) mem[ptr[ADDR_W-1:0]] <= wd;
   end

   imem_window #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) u_window (
      .rd_pc    (rd_pc),
      .mem      (mem),
      .rd_instr (rd_instr),
      .rd_err   (rd_err)
   );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: clear, loads, overflow, stalls, bounds, reset.
module tb_imem_loader;
   localparam int MEM_BYTES = 1024;
   localparam int ADDR_W    = 10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         load_start = 1'b0;
   logic [9:0]   load_base = '0;
   logic         in_valid = 1'b0;
   logic [7:0]   in_data = '0;
   logic         in_last = 1'b0;
   logic         in_ready, busy, load_done, load_err;
   logic [10:0]  load_count;
   logic [63:0]  rd_pc = '0;
   logic [79:0]  rd_instr;
   logic         rd_err;

   imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .busy(busy), .load_done(load_done), .load_err(load_err), .load_count(load_count),
      .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_err(rd_err)
   );

   always #5 clk = ~clk;

   typedef struct {int addr; logic [7:0] data;} sb_t;
   sb_t        sb[$];
   logic [7:0] model[MEM_BYTES];
   logic [7:0] stim[32];
   int         n_chk = 0;
   int         n_fail = 0;

   function automatic logic [79:0] model_window(input logic [63:0] pc);
      logic [79:0] w;
      logic [64:0] a;
      w = '0;
      for (int i = 0; i < 10; i++) begin
         a = {1'b0, pc} + 65'(i);
         if (a < 65'(MEM_BYTES)) w[i*8 +: 8] = model[int'(a)];
      end
      return w;
   endfunction

   // Drives one stream of n bytes from stim[]; returns load_done pulses seen.
   task automatic run_load(input int base, input int n, input bit stall, input bit poke,
                           output int pulses);
      int i = 0;
      int stalls = 0;
      pulses = 0;
      @(negedge clk);
      load_start = 1'b1;
      load_base  = 10'(base);
      @(negedge clk);
      load_start = 1'b0;
      n_chk++;
      if (in_ready !== 1'b1 || load_err !== 1'b0 || load_count !== 11'd0) begin
         n_fail++;
         $display("FAIL start_accept rdy=%b err=%b cnt=%0d exp 1/0/0", in_ready, load_err, load_count);
      end
      while (i < n) begin
         if (stall && stalls < 40 && $urandom_range(0, 2) == 0) begin
            stalls++;
            in_valid   = 1'b0;
            in_data    = 8'hEE;
            in_last    = 1'b1;
            load_start = poke;
            load_base  = 10'd500;
         end else begin
            n_chk++;
            if (in_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL in_ready_beat%0d got %b exp 1", i, in_ready);
            end
            in_valid   = 1'b1;
            in_data    = stim[i];
            in_last    = (i == n - 1);
            load_start = 1'b0;
            if (base + i < MEM_BYTES) begin
               model[base + i] = stim[i];
               sb.push_back('{base + i, stim[i]});
            end
            i++;
         end
         @(negedge clk);
         pulses += int'(load_done);
      end
      in_valid   = 1'b0;
      in_last    = 1'b0;
      load_start = 1'b0;
      repeat (2) begin
         @(negedge clk);
         pulses += int'(load_done);
      end
   endtask

   task automatic drain_scoreboard(input string tag);
      sb_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         rd_pc = 64'(e.addr);
         #1;
         n_chk++;
         if (rd_instr[7:0] !== e.data) begin
            n_fail++;
            $display("FAIL %s_byte@%0d got %h exp %h", tag, e.addr, rd_instr[7:0], e.data);
         end
      end
   endtask

   task automatic wait_clear(output int cycles);
      cycles = 0;
      while (busy === 1'b1 && cycles < 3000) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic test_reset();
      int cyc;
      #1;
      n_chk++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 ||
          load_count !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_vals rdy=%b busy=%b done=%b err=%b cnt=%0d exp 0/1/0/0/0",
                  in_ready, busy, load_done, load_err, load_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_clear(cyc);
      n_chk++;
      if (cyc != MEM_BYTES) begin
         n_fail++;
         $display("FAIL clear_len got %0d exp %0d", cyc, MEM_BYTES);
      end
      rd_pc = 64'd0;
      #1;
      n_chk++;
      if (rd_instr !== 80'h0 || rd_err !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_read got %h err %b exp 0 err 0", rd_instr, rd_err);
      end
   endtask

   task automatic test_load();
      int p;
      stim[0] = 8'h30; stim[1] = 8'hF3; stim[2] = 8'h0A;
      for (int i = 3; i < 10; i++) stim[i] = 8'h00;
      run_load(30, 10, 1'b0, 1'b0, p);
      n_chk++;
      if (p != 1 || load_count !== 11'd10 || load_err !== 1'b0) begin
         n_fail++;
         $display("FAIL load30_status pulses=%0d cnt=%0d err=%b exp 1/10/0", p, load_count, load_err);
      end
      rd_pc = 64'd30;
      #1;
      n_chk++;
      if (rd_instr !== 80'h000000000000000AF330) begin
         n_fail++;
         $display("FAIL load30_window got %h exp 000000000000000af330", rd_instr);
      end
      drain_scoreboard("load30");
   endtask

   task automatic test_overflow();
      int p;
      for (int i = 0; i < 6; i++) stim[i] = 8'hA1 + 8'(i);
      run_load(1020, 6, 1'b0, 1'b0, p);
      n_chk++;
      if (p != 0 || load_count !== 11'd4 || load_err !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_status pulses=%0d cnt=%0d err=%b exp 0/4/1", p, load_count, load_err);
      end
      n_chk++;
      if (busy !== 1'b0 || in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_idle busy=%b rdy=%b exp 0/0", busy, in_ready);
      end
      rd_pc = 64'd0;
      #1;
      n_chk++;
      if (rd_instr[15:0] !== 16'h0) begin
         n_fail++;
         $display("FAIL ovf_nowrap got %h exp 0000", rd_instr[15:0]);
      end
      drain_scoreboard("ovf");
   endtask

   task automatic test_stall();
      int p;
      for (int i = 0; i < 20; i++) stim[i] = 8'h40 + 8'(i);
      run_load(0, 20, 1'b1, 1'b1, p);
      n_chk++;
      if (p != 1 || load_count !== 11'd20 || load_err !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_status pulses=%0d cnt=%0d err=%b exp 1/20/0", p, load_count, load_err);
      end
      rd_pc = 64'd500;
      #1;
      n_chk++;
      if (rd_instr !== model_window(64'd500)) begin
         n_fail++;
         $display("FAIL stall_poke_ignored got %h exp %h", rd_instr, model_window(64'd500));
      end
      drain_scoreboard("stall");
   endtask

   task automatic test_bounds();
      rd_pc = 64'd1014;
      #1;
      n_chk++;
      if (rd_err !== 1'b0 || rd_instr !== model_window(64'd1014)) begin
         n_fail++;
         $display("FAIL bound1014 got %h err %b exp %h err 0", rd_instr, rd_err, model_window(64'd1014));
      end
      rd_pc = 64'd1015;
      #1;
      n_chk++;
      if (rd_err !== 1'b1 || rd_instr[79:72] !== 8'h00 || rd_instr !== model_window(64'd1015)) begin
         n_fail++;
         $display("FAIL bound1015 got %h err %b exp %h err 1", rd_instr, rd_err, model_window(64'd1015));
      end
      rd_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      #1;
      n_chk++;
      if (rd_err !== 1'b1 || rd_instr !== 80'h0) begin
         n_fail++;
         $display("FAIL bound_high got %h err %b exp 0 err 1", rd_instr, rd_err);
      end
   endtask

   task automatic test_midload_reset();
      int cyc;
      @(negedge clk);
      load_start = 1'b1;
      load_base  = 10'd100;
      @(negedge clk);
      load_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'hC0 + 8'(i);
         in_last  = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b0;
      rd_pc = 64'd100;
      #1;
      n_chk++;
      if (rd_instr[23:0] !== 24'hC2C1C0 || load_count !== 11'd3) begin
         n_fail++;
         $display("FAIL pre_reset got %h cnt=%0d exp c2c1c0 cnt=3", rd_instr[23:0], load_count);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || load_done !== 1'b0 || load_err !== 1'b0 ||
          load_count !== 11'd0) begin
         n_fail++;
         $display("FAIL midreset_vals rdy=%b busy=%b done=%b err=%b cnt=%0d exp 0/1/0/0/0",
                  in_ready, busy, load_done, load_err, load_count);
      end
      for (int i = 0; i < MEM_BYTES; i++) model[i] = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      wait_clear(cyc);
      n_chk++;
      if (cyc != MEM_BYTES) begin
         n_fail++;
         $display("FAIL reclear_len got %0d exp %0d", cyc, MEM_BYTES);
      end
      rd_pc = 64'd100;
      #1;
      n_chk++;
      if (rd_instr !== 80'h0) begin
         n_fail++;
         $display("FAIL reclear_100 got %h exp 0", rd_instr);
      end
      rd_pc = 64'd30;
      #1;
      n_chk++;
      if (rd_instr !== 80'h0) begin
         n_fail++;
         $display("FAIL reclear_30 got %h exp 0", rd_instr);
      end
   endtask

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) model[i] = 8'h00;
      test_reset();
      test_load();
      test_overflow();
      test_stall();
      test_bounds();
      test_midload_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
